mpadd_seq: RTL and testbench

Multi-precision add/subtract sequencer that sits between an operand stream and the 16-bit adder datapath (adder16, ripple or lookahead variant). It splits an N-limb operation into LIMBS beats, least-significant limb first. On each beat it drives the adder's a/b/cin, captures s/cout into an output register, and chains the carry into the next limb. On the last limb it also reports the final carry and signed overflow.

---
 rtl/mpadd_pkg.sv | 12 +
 rtl/mpadd_seq.sv | 122 ++++++++++++
 tb/tb_mpadd_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mpadd_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
// Holds the default limb width and the sequencer state encoding.
package mpadd_pkg;

    localparam int W_DEF = 16;

    typedef enum logic {
        FIRST = 1'b0,
        BODY  = 1'b1
    } mpadd_state_t;

endpackage : mpadd_pkg

// File: rtl/mpadd_seq.sv
// Multi-precision add/subtract sequencer: feeds one limb per beat (LS first) to an
// external combinational adder, chains the carry, and registers each result limb.
module mpadd_seq
    import mpadd_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LIMBS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_sub,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_cin,
    input  logic [W-1:0] add_s,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_s,
    output logic         out_last,
    output logic         out_cout,
    output logic         out_ovf
);

    localparam int            IW       = $clog2(LIMBS) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LIMBS - 1);

    mpadd_state_t  r_state;
    mpadd_state_t  w_state_next;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_next;
    logic          r_carry;
    logic          r_sub;
    logic [W-1:0]  r_out_s;
    logic          r_out_valid;
    logic          r_out_last;
    logic          r_out_cout;
    logic          r_out_ovf;

    logic w_accept;
    logic w_first;
    logic w_sub_eff;
    logic w_is_last;
    logic w_ovf;

    // Single output stage: a new limb may enter whenever the held one leaves.
    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_first   = (r_state == FIRST);
    assign w_sub_eff = w_first ? in_sub : r_sub;
    assign w_is_last = (r_idx == LAST_IDX);

    assign add_a   = in_a;
    assign add_b   = w_sub_eff ? ~in_b : in_b;
    assign add_cin = w_first ? in_sub : r_carry;

    // MSB-column xor recovers the carry into the sign bit; xor with cout gives overflow.
    assign w_ovf = add_cout ^ (in_a[W-1] ^ add_b[W-1] ^ add_s[W-1]);

    assign out_valid = r_out_valid;
    assign out_s     = r_out_s;
    assign out_last  = r_out_last;
    assign out_cout  = r_out_cout;
    assign out_ovf   = r_out_ovf;

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        if (w_accept) begin
            if (w_is_last) begin
                w_state_next = FIRST;
                w_idx_next   = '0;
            end else begin
                w_state_next = BODY;
                w_idx_next   = r_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FIRST;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            if (w_accept) begin
                r_carry <= add_cout;
                if (w_first) begin
                    r_sub <= in_sub;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_s     <= '0;
            r_out_last  <= 1'b0;
            r_out_cout  <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_s     <= add_s;
            r_out_last  <= w_is_last;
            if (w_is_last) begin
                r_out_cout <= add_cout;
                r_out_ovf  <= w_ovf;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule : mpadd_seq

// File: tb/tb_mpadd_seq.sv
// Scoreboard bench for mpadd_seq with a behavioural 16-bit adder in the loop.
module tb_mpadd_seq;

    localparam int W     = 16;
    localparam int LIMBS = 4;
    localparam int OW    = W * LIMBS;

    typedef struct {
        logic [W-1:0] s;
        logic         last;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] add_s;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_s;
    logic         out_last;
    logic         out_cout;
    logic         out_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    mpadd_seq #(.W(W), .LIMBS(LIMBS)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_last(out_last), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full-width reference: operand B is inverted and +1 injected for subtraction.
    function automatic void model(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic sub,
                                  output logic [OW-1:0] s, output logic cout, output logic ovf);
        logic [OW-1:0] bb;
        logic [OW:0]   sum;
        bb   = sub ? ~b : b;
        sum  = {1'b0, a} + {1'b0, bb} + {{OW{1'b0}}, sub};
        s    = sum[OW-1:0];
        cout = sum[OW];
        ovf  = (a[OW-1] == bb[OW-1]) && (s[OW-1] != a[OW-1]);
    endfunction

    // Drives limbs 0..nlimbs-1 of one operation; optional idle gap between limbs.
    task automatic run_op(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic sub,
                          input int nlimbs, input int gap);
        logic [OW-1:0] s;
        logic cout, ovf;
        bit ok;
        exp_t e;
        model(a, b, sub, s, cout, ovf);
        for (int i = 0; i < nlimbs; i++) begin
            in_valid = 1'b1;
            in_a     = a[i*W +: W];
            in_b     = b[i*W +: W];
            in_sub   = (i == 0) ? sub : ~sub;
            ok = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("in_ready_timeout", {63'd0, ok}, 64'd1);
            if (i == 0) chk("cin_first", {63'd0, add_cin}, {63'd0, sub});
            e.s = s[i*W +: W]; e.last = (i == LIMBS - 1); e.cout = cout; e.ovf = ovf;
            if (ok) exp_q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            $display("[TB] limb s=%h last=%b cout=%b ovf=%b", out_s, out_last, out_cout, out_ovf);
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_s", {48'd0, out_s}, {48'd0, e.s});
                chk("out_last", {63'd0, out_last}, {63'd0, e.last});
                if (e.last) begin
                    chk("out_cout", {63'd0, out_cout}, {63'd0, e.cout});
                    chk("out_ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
                end
            end
        end
    end

    task automatic stall_ctl();
        logic [W-1:0] held;
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("stall_out_valid_timeout", {63'd0, seen}, 64'd1);
        held = out_s;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_out_s", {48'd0, out_s}, {48'd0, held});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    initial begin
        bit drained;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_s", {48'd0, out_s}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_cout", {63'd0, out_cout}, 64'd0);
        chk("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
        @(posedge clk);
        #1;

        run_op(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, LIMBS, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, LIMBS, 0);
        run_op(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1, LIMBS, 0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, LIMBS, 0);

        out_ready = 1'b0;
        fork
            run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, LIMBS, 0);
            stall_ctl();
        join

        for (int k = 0; k < 6; k++) begin
            run_op({$urandom(), $urandom()}, {$urandom(), $urandom()}, k[0], LIMBS, k % 3);
        end

        run_op(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 2, 0);
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_op(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b1, LIMBS, 0);

        drained = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        chk("drain", {63'd0, drained}, 64'd1);
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mpadd_seq
